shape_raster_writer: RTL and testbench

Downstream consumer of the shape processing unit's 172-bit draw packet (`{shape, code, color, 8 packed vertices}`). The block accepts one packet at a time and walks the closed polygon edge by edge using integer Bresenham stepping. Each rasterised pixel becomes one framebuffer write (address, 6-bit colour) under a valid/ready handshake. It sits between the SPU result path and the framebuffer/VGA memory write port.

---
 rtl/spu_pkg.sv | 18 +
 rtl/bresenham_step.sv | 56 +++++
 rtl/shape_raster_writer.sv | 102 ++++++++++
 tb/tb_shape_raster_writer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: draw packet layout, opcode, vertex count helper and writer FSM states
package spu_pkg;
    localparam int COORD_W = 10;
    localparam int VERT_W = 20;
    localparam int NVERT = 8;
    localparam int COLOR_W = 6;
    localparam int CODE_W = 4;
    localparam int SHAPE_W = 2;
    localparam int COLOR_LSB = 160;
    localparam int CODE_LSB = 166;
    localparam int SHAPE_LSB = 170;
    localparam int PKT_W = 172;
    localparam logic [CODE_W-1:0] OP_DR8 = 4'b0101;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_DRAW, S_NEXT, S_DONE} state_t;
    function automatic logic [3:0] vert_count(input logic [SHAPE_W-1:0] shape);
        return shape == 2'b00 ? 4'd3 : shape == 2'b01 ? 4'd4 : shape == 2'b10 ? 4'd6 : 4'd8;
    endfunction
endpackage

// File: rtl/bresenham_step.sv
// bresenham_step: integer line stepper, current point plus last flag at the end point
module bresenham_step import spu_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);
    logic [COORD_W-1:0] xe, ye, adx, ady;
    logic signed [11:0] dx, dy, err;
    logic signed [12:0] e2;
    logic sx_neg, sy_neg, step_x, step_y;
    // e2 needs one extra bit: 2*err can exceed the 12-bit signed range
    always_comb begin
        adx = x1 >= x0 ? x1 - x0 : x0 - x1;
        ady = y1 >= y0 ? y1 - y0 : y0 - y1;
        e2 = {err, 1'b0};
        step_x = e2 >= $signed({dy[11], dy});
        step_y = e2 <= $signed({dx[11], dx});
        last = x == xe && y == ye;
    end
    // load edge terms, or take one Bresenham step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
            xe <= '0;
            ye <= '0;
            dx <= '0;
            dy <= '0;
            err <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (load) begin
            x <= x0;
            y <= y0;
            xe <= x1;
            ye <= y1;
            dx <= $signed({2'b00, adx});
            dy <= -$signed({2'b00, ady});
            err <= $signed({2'b00, adx}) - $signed({2'b00, ady});
            sx_neg <= x1 < x0;
            sy_neg <= y1 < y0;
        end else if (advance) begin
            err <= err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);
            x <= step_x ? (sx_neg ? x - 10'd1 : x + 10'd1) : x;
            y <= step_y ? (sy_neg ? y - 10'd1 : y + 10'd1) : y;
        end
    end
endmodule

// File: rtl/shape_raster_writer.sv
// shape_raster_writer: walks a polygon draw packet into clipped framebuffer pixel writes
module shape_raster_writer import spu_pkg::*; #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int ADDR_W = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_valid,
    output logic               pkt_ready,
    input  logic [PKT_W-1:0]   pkt_data,
    output logic               fb_valid,
    input  logic               fb_ready,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               busy,
    output logic               done
);
    state_t state, state_n;
    logic [SHAPE_W-1:0] shape;
    logic [CODE_W-1:0] code;
    logic [COLOR_W-1:0] color;
    logic [VERT_W*NVERT-1:0] verts;
    logic [2:0] idx, end_idx;
    logic [3:0] nv, sel, nxt;
    logic [COORD_W-1:0] x0, y0, x1, y1, x, y;
    logic [ADDR_W-1:0] addr;
    logic load, last, free, issue, on;
    assign pkt_ready = state == S_IDLE;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    // sel is the edge about to be loaded: 0 from LOAD, idx+1 from NEXT
    always_comb begin
        nv = vert_count(shape);
        sel = state == S_LOAD ? 4'd0 : {1'b0, idx} + 4'd1;
        nxt = sel + 4'd1;
        end_idx = nxt == nv ? 3'd0 : nxt[2:0];
        {y0, x0} = verts[VERT_W*sel[2:0] +: VERT_W];
        {y1, x1} = verts[VERT_W*end_idx +: VERT_W];
        load = (state == S_LOAD && code == OP_DR8) || (state == S_NEXT && sel < nv);
        free = !fb_valid || fb_ready;
        issue = (state == S_SETUP || state == S_DRAW) && !last && free;
        on = 32'(x) < H_RES && 32'(y) < V_RES;
        addr = ADDR_W'(32'(y) * H_RES + 32'(x));
    end
    bresenham_step u_step (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .advance(issue),
        .x0(x0),
        .y0(y0),
        .x1(x1),
        .y1(y1),
        .x(x),
        .y(y),
        .last(last)
    );
    // next state; DONE waits until the final pixel write has drained
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: state_n = pkt_valid ? S_LOAD : S_IDLE;
            S_LOAD: state_n = code == OP_DR8 ? S_SETUP : S_DONE;
            S_SETUP: state_n = last ? S_NEXT : free ? S_DRAW : S_SETUP;
            S_DRAW: state_n = last ? S_NEXT : S_DRAW;
            S_NEXT: state_n = sel < nv ? S_SETUP : free ? S_DONE : S_NEXT;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    // state, packet capture, edge index and the registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            shape <= '0;
            code <= '0;
            color <= '0;
            verts <= '0;
            idx <= '0;
            fb_valid <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            state <= state_n;
            if (pkt_valid && pkt_ready) begin
                shape <= pkt_data[SHAPE_LSB +: SHAPE_W];
                code <= pkt_data[CODE_LSB +: CODE_W];
                color <= pkt_data[COLOR_LSB +: COLOR_W];
                verts <= pkt_data[VERT_W*NVERT-1:0];
            end
            if (load) idx <= sel[2:0];
            if (issue) begin
                fb_valid <= on;
                fb_addr <= addr;
                fb_data <= color;
            end else if (fb_ready) begin
                fb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shape_raster_writer.sv
// tb_shape_raster_writer: directed checks of polygon rasterisation, clipping, stalls and reset
module tb_shape_raster_writer;
    logic clk = 1'b0, rst_n = 1'b0, pkt_valid = 1'b0, fb_ready = 1'b1, toggle = 1'b0;
    logic [171:0] pkt_data = '0;
    logic pkt_ready, fb_valid, busy, done;
    logic [18:0] fb_addr;
    logic [5:0] fb_data;
    int errors = 0, checks = 0, ndone = 0;
    logic [18:0] wa[$];
    logic [5:0] wd[$];
    logic stalled = 1'b0;
    logic [18:0] stall_addr = '0;
    logic [5:0] stall_data = '0;
    int xs[8], ys[8];
    int tri_exp[12] = '{0, 1, 2, 3, 4, 643, 1282, 1921, 2560, 1920, 1280, 640};

    always #5 clk = ~clk;

    shape_raster_writer dut (
        .clk(clk),
        .rst_n(rst_n),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_data(pkt_data),
        .fb_valid(fb_valid),
        .fb_ready(fb_ready),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // record accepted writes and done pulses; verify the write port holds while stalled
    always @(posedge clk) begin
        if (stalled) begin
            chk("stall_valid", fb_valid, 1);
            chk("stall_addr", fb_addr, stall_addr);
            chk("stall_data", fb_data, stall_data);
        end
        stalled <= fb_valid && !fb_ready && rst_n;
        stall_addr <= fb_addr;
        stall_data <= fb_data;
        if (fb_valid && fb_ready) begin
            wa.push_back(fb_addr);
            wd.push_back(fb_data);
        end
        if (done) ndone++;
    end

    always @(negedge clk) fb_ready = toggle ? !fb_ready : 1'b1;

    function automatic logic [171:0] mk(input logic [1:0] s, input logic [3:0] c, input logic [5:0] col);
        logic [171:0] p;
        p = '0;
        p[171:170] = s;
        p[169:166] = c;
        p[165:160] = col;
        for (int i = 0; i < 8; i++) begin
            p[20*i +: 10] = 10'(xs[i]);
            p[20*i+10 +: 10] = 10'(ys[i]);
        end
        return p;
    endfunction

    // offer one packet; returns on the negedge one cycle after the handshake edge
    task automatic send(input logic [1:0] s, input logic [3:0] c, input logic [5:0] col);
        wa.delete();
        wd.delete();
        @(negedge clk);
        pkt_valid = 1'b1;
        pkt_data = mk(s, c, col);
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 5000 && ndone == d0; i++) @(negedge clk);
        chk("done_timeout", ndone != d0, 1);
        repeat (3) @(negedge clk);
        chk("done_once", ndone - d0, 1);
    endtask

    task automatic check_tri(input string tag);
        chk({tag, "_count"}, wa.size(), 12);
        for (int i = 0; i < 12 && i < wa.size(); i++) begin
            chk({tag, "_addr"}, wa[i], tri_exp[i]);
            chk({tag, "_data"}, wd[i], 6'h2A);
        end
    endtask

    task automatic set_tri();
        xs = '{0, 4, 0, 0, 0, 0, 0, 0};
        ys = '{0, 0, 4, 0, 0, 0, 0, 0};
    endtask

    initial begin
        int d0, bad;
        #2;
        chk("rst_pkt_ready", pkt_ready, 1);
        chk("rst_fb_valid", fb_valid, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        set_tri();
        d0 = ndone;
        send(2'b00, 4'b0101, 6'h2A);
        chk("t1_busy", busy, 1);
        chk("t1_pkt_ready", pkt_ready, 0);
        @(negedge clk);
        chk("t2_fb_valid", fb_valid, 0);
        @(negedge clk);
        chk("t3_fb_valid", fb_valid, 1);
        chk("t3_fb_addr", fb_addr, 0);
        wait_done(d0);
        check_tri("tri");

        toggle = 1'b1;
        d0 = ndone;
        send(2'b00, 4'b0101, 6'h2A);
        wait_done(d0);
        check_tri("tri_stall");
        toggle = 1'b0;

        xs = '{600, 700, 700, 600, 0, 0, 0, 0};
        ys = '{10, 10, 110, 110, 0, 0, 0, 0};
        d0 = ndone;
        send(2'b01, 4'b0101, 6'h11);
        wait_done(d0);
        chk("sq_count", wa.size(), 179);
        if (wa.size() > 0) chk("sq_first", wa[0], 7000);
        bad = 0;
        foreach (wa[i]) if (wa[i] % 640 < 600) bad++;
        chk("sq_offscreen", bad, 0);

        set_tri();
        d0 = ndone;
        send(2'b00, 4'b0010, 6'h2A);
        chk("ign_done_t1", done, 0);
        @(negedge clk);
        chk("ign_done_t2", done, 1);
        chk("ign_ready_t2", pkt_ready, 0);
        @(negedge clk);
        chk("ign_done_t3", done, 0);
        chk("ign_ready_t3", pkt_ready, 1);
        repeat (3) @(negedge clk);
        chk("ign_writes", wa.size(), 0);
        chk("ign_done_once", ndone - d0, 1);

        xs = '{5, 5, 5, 5, 5, 5, 5, 5};
        ys = '{5, 5, 5, 5, 5, 5, 5, 5};
        d0 = ndone;
        send(2'b00, 4'b0101, 6'h2A);
        wait_done(d0);
        chk("degen_writes", wa.size(), 0);

        xs = '{100, 110, 120, 120, 110, 100, 90, 90};
        ys = '{100, 100, 110, 120, 130, 130, 120, 110};
        d0 = ndone;
        send(2'b11, 4'b0101, 6'h3F);
        repeat (12) @(negedge clk);
        chk("oct_busy", busy, 1);
        chk("oct_drawing", wa.size() > 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pkt_ready", pkt_ready, 1);
        chk("arst_fb_valid", fb_valid, 0);
        chk("arst_fb_addr", fb_addr, 0);
        chk("arst_fb_data", fb_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_no_done", ndone - d0, 0);

        set_tri();
        d0 = ndone;
        send(2'b00, 4'b0101, 6'h2A);
        wait_done(d0);
        check_tri("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
